// File: rtl/legv8_pkg.sv
// LEGv8 opcodes and encoder/loader types shared by the encoder, the loader and the decoders.
package legv8_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORR  = 3'd3,
        OP_LDUR = 3'd4,
        OP_STUR = 3'd5,
        OP_CBZ  = 3'd6,
        OP_MOVZ = 3'd7
    } enc_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;

    // addr9 fits iff bits [18:8] of the signed immediate are all copies of the sign bit
    function automatic logic d_imm_in_range(input logic [18:0] imm);
        return (imm[18:8] == '0) || (imm[18:8] == '1);
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational LEGv8 encoder: symbolic request fields to a 32-bit machine word.
module instr_encode
    import legv8_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    input  logic [1:0]  hw,
    output logic [31:0] word,
    output logic        range_err
);

    enc_op_t op_e;
    assign op_e = enc_op_t'(op);

    always_comb begin
        word      = '0;
        range_err = 1'b0;
        case (op_e)
            OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
            OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
            OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
            OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
            OP_LDUR: begin
                word      = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
                range_err = !d_imm_in_range(imm);
            end
            OP_STUR: begin
                word      = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
                range_err = !d_imm_in_range(imm);
            end
            OP_CBZ:  word = {OPC_CBZ, imm, rd};
            OP_MOVZ: begin
                word      = {OPC_MOVZ, hw, imm[15:0], rd};
                range_err = (imm[18:16] != 3'b000);
            end
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests, encodes them and writes them
// sequentially into instruction memory through a stallable write port.
module instr_encoder_loader
    import legv8_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [18:0]       req_imm,
    input  logic [1:0]        req_hw,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_range,
    output logic              err_full
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_inc;
    logic [31:0]       word_q;
    logic              last_q;
    logic              err_range_q;
    logic              err_full_q;

    logic [31:0]       enc_word;
    logic              enc_range_err;

    logic              start_run;
    logic              accept;
    logic              write_ok;
    logic              hit_full;

    instr_encode u_encode (
        .op        (req_op),
        .rd        (req_rd),
        .rn        (req_rn),
        .rm        (req_rm),
        .imm       (req_imm),
        .hw        (req_hw),
        .word      (enc_word),
        .range_err (enc_range_err)
    );

    assign count_inc = count_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        imem_we    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        start_run  = 1'b0;
        accept     = 1'b0;
        write_ok   = 1'b0;
        hit_full   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
                if (imem_ready) begin
                    write_ok = 1'b1;
                    if (last_q) begin
                        state_next = DONE;
                    end else if (count_inc == DEPTH_C) begin
                        hit_full   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    start_run  = 1'b1;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= BASE_C;
            count_q     <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_full_q  <= 1'b0;
        end else begin
            if (start_run) begin
                addr_q      <= BASE_C;
                count_q     <= '0;
                err_range_q <= 1'b0;
                err_full_q  <= 1'b0;
            end
            if (accept) begin
                word_q <= enc_word;
                last_q <= req_last;
                if (enc_range_err) err_range_q <= 1'b1;
            end
            // address wraps naturally at 2**ADDR_W
            if (write_ok) begin
                count_q <= count_inc;
                addr_q  <= addr_q + 1'b1;
                if (hit_full) err_full_q <= 1'b1;
            end
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign count      = count_q;
    assign err_range  = err_range_q;
    assign err_full   = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against an arithmetic encoding model.
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        req_op = '0;
    logic [4:0]        req_rd = '0, req_rn = '0, req_rm = '0;
    logic [18:0]       req_imm = '0;
    logic [1:0]        req_hw = '0;
    logic              req_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready = 1'b0;
    logic              busy, done;
    logic [ADDR_W:0]   count;
    logic              err_range, err_full;

    int n_cmp = 0;
    int n_bad = 0;

    int  exp_addr, exp_count;
    bit  m_err_range, m_err_full, m_done;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .req_rn     (req_rn),
        .req_rm     (req_rm),
        .req_imm    (req_imm),
        .req_hw     (req_hw),
        .req_last   (req_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .err_range  (err_range),
        .err_full   (err_full)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder built from field positions with plain arithmetic.
    function automatic void ref_enc(input int op, input int rd, input int rn, input int rm,
                                    input int imm, input int hw,
                                    output logic [31:0] w, output bit rng);
        longint v;
        int s, a9, opc;
        s   = (imm >= 262144) ? imm - 524288 : imm;
        rng = 1'b0;
        v   = 0;
        case (op)
            0, 1, 2, 3: begin
                opc = (op == 0) ? 'b10001011000 : (op == 1) ? 'b11001011000 :
                      (op == 2) ? 'b10001010000 : 'b10101010000;
                v = longint'(opc) * (2**21) + rm * (2**16) + rn * 32 + rd;
            end
            4, 5: begin
                opc = (op == 4) ? 'b11111000010 : 'b11111000000;
                a9  = ((s % 512) + 512) % 512;
                rng = (s < -256) || (s > 255);
                v   = longint'(opc) * (2**21) + a9 * (2**12) + rn * 32 + rd;
            end
            6: v = longint'('b10110100) * (2**24) + longint'(imm) * 32 + rd;
            default: begin
                rng = (imm > 65535);
                v   = longint'('b110100101) * (2**23) + hw * (2**21)
                      + longint'(imm % 65536) * 32 + rd;
            end
        endcase
        w = 32'(v % 64'h1_0000_0000);
    endfunction

    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr    = BASE_ADDR;
        exp_count   = 0;
        m_err_range = 0;
        m_err_full  = 0;
        m_done      = 0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_count", 32'(count), 32'd0);
        chk("start_addr", 32'(imem_addr), 32'(exp_addr));
        chk("start_errs", {30'd0, err_range, err_full}, 32'd0);
    endtask

    task automatic push(input int op, input int rd, input int rn, input int rm,
                        input int imm, input int hw, input bit last, input int stall);
        logic [31:0] w;
        bit rng;
        int n;
        ref_enc(op, rd, rn, rm, imm, hw, w, rng);
        req_op = op[2:0]; req_rd = rd[4:0]; req_rn = rn[4:0]; req_rm = rm[4:0];
        req_imm = imm[18:0]; req_hw = hw[1:0]; req_last = last;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (rng) m_err_range = 1;
        chk("we_latency", 32'(imem_we), 32'd1);
        chk("wr_addr", 32'(imem_addr), 32'(exp_addr));
        chk("wr_data", imem_wdata, w);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_we", 32'(imem_we), 32'd1);
            chk("stall_addr", 32'(imem_addr), 32'(exp_addr));
            chk("stall_data", imem_wdata, w);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        exp_count++;
        exp_addr = (exp_addr + 1) % (2**ADDR_W);
        if (last) m_done = 1;
        else if (exp_count == DEPTH) begin
            m_done = 1;
            m_err_full = 1;
        end
        chk("count", 32'(count), 32'(exp_count));
        chk("next_addr", 32'(imem_addr), 32'(exp_addr));
        chk("err_range", 32'(err_range), 32'(m_err_range));
        chk("err_full", 32'(err_full), 32'(m_err_full));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(!m_done));
        chk("we_after", 32'(imem_we), 32'd0);
    endtask

    function automatic int rand_imm(input int op);
        int v;
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 524287));
        if (op == 7) return int'($urandom_range(0, 65535));
        v = int'($urandom_range(0, 256));
        if ($urandom_range(0, 1) == 1 && v != 0) return 524288 - v;
        return (v > 255) ? 255 : v;
    endfunction

    initial begin
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", {27'd0, busy, done, req_ready, err_range, err_full}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        start_run();
        push(0, 3, 1, 2, 0, 0, 1'b0, 0);
        chk("add_word", imem_wdata, 32'h8B020023);
        push(1, 4, 5, 6, 0, 0, 1'b1, 0);

        start_run();
        push(4, 9, 0, 0, 8, 0, 1'b0, 0);
        chk("ldur_word", imem_wdata, 32'hF8408009);
        push(6, 0, 0, 0, 524286, 0, 1'b0, 3);
        chk("cbz_word", imem_wdata, 32'hB4FFFFC0);
        push(7, 5, 0, 0, 32'h1234, 1, 1'b1, 1);
        chk("movz_word", imem_wdata, 32'hD2A24685);

        start_run();
        push(5, 1, 2, 0, 300, 0, 1'b0, 0);
        chk("stur_addr9", 32'(imem_wdata[20:12]), 32'h12C);
        push(2, 7, 8, 9, 0, 0, 1'b1, 0);
        chk("range_sticky", 32'(err_range), 32'd1);
        start_run();

        push(3, 1, 1, 1, 0, 0, 1'b0, 0);
        push(4, 2, 2, 0, 5, 0, 1'b0, 2);
        push(0, 3, 3, 3, 0, 0, 1'b0, 0);
        push(7, 4, 0, 0, 70000, 2, 1'b0, 0);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("full_no_accept", 32'(req_ready), 32'd0);
            chk("full_count", 32'(count), 32'd4);
        end
        req_valid = 1'b0;

        start_run();
        req_op = 3'd0; req_last = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("pre_rst_we", 32'(imem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_we", 32'(imem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        start_run();
        push(1, 10, 11, 12, 0, 0, 1'b1, 0);

        for (int r = 0; r < 40; r++) begin
            int len, op;
            bit last;
            len = int'($urandom_range(1, DEPTH));
            start_run();
            for (int i = 0; i < len; i++) begin
                op   = int'($urandom_range(0, 7));
                last = (i == len - 1) && (len < DEPTH || $urandom_range(0, 1) == 1);
                push(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), rand_imm(op), int'($urandom_range(0, 3)),
                     last, int'($urandom_range(0, 2)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
